// File: rtl/spi_pkg.sv
// Shared constants, header field positions and FSM encoding for the SPI
// serial-to-parallel delay-register front end.
package spi_pkg;
  localparam int unsigned HDR_W     = 8;
  localparam int unsigned DATA_BITS = 16;
  localparam int unsigned RW_BIT    = 7;
  localparam int unsigned CH_MSB    = 1;
  localparam int unsigned CH_LSB    = 0;
  localparam int unsigned CNT_W     = 5;

  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_READ   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// N-flop synchronizer with rise/fall detect on the last stage; edge strobes
// are one clk wide and appear STAGES clk after the pin transition.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~dly_q;
  assign fall_o = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/spi_s2p_ctrl.sv
// SPI slave: 8-bit header selects a channel, then either a 16-bit write into
// the 14-bit delay bank or a held readback of that channel to the p2s stage.
module spi_s2p_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned    DW          = 14,
  parameter int unsigned    NCH         = 4,
  parameter int unsigned    SYNC_STAGES = 2,
  parameter logic [DW-1:0]  DLY_RST     = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              cs,
  input  logic              mosi,
  output logic              head_flag,
  output logic [DW-1:0]     rd_data,
  output logic [NCH*DW-1:0] ch_dly,
  output logic              wr_pulse,
  output logic              frame_err
);

  localparam int unsigned CH_W = CH_MSB - CH_LSB + 1;

  logic sck_rise, sck_lvl_unused, sck_fall_unused;
  logic cs_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst(rst), .async_i(sck),
    .sync_o(sck_lvl_unused), .rise_o(sck_rise), .fall_o(sck_fall_unused)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .async_i(cs),
    .sync_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [DW-2:0]              shreg_q, shreg_d;
  logic [DW-1:0]              shift_val;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic                       head_q, head_d;
  logic [DW-1:0]              rd_q, rd_d;
  logic [NCH-1:0][DW-1:0]     dly_q, dly_d;
  logic                       wr_q, wr_d;
  logic                       err_q, err_d;
  logic [SYNC_STAGES:0]       fill_q;
  logic                       armed_q;

  assign shift_val = {shreg_q, mosi_s};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    ch_d    = ch_q;
    head_d  = head_q;
    rd_d    = rd_q;
    dly_d   = dly_q;
    wr_d    = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall && armed_q) begin
          state_d = ST_HEADER;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_HEADER: begin
        if (sck_rise) begin
          shreg_d = shift_val[DW-2:0];
          cnt_d   = sat_inc(cnt_q);
        end
        if (sck_rise && cnt_q == HDR_LAST) begin
          ch_d  = shift_val[CH_MSB:CH_LSB];
          cnt_d = '0;
          if (cs_rise) begin
            state_d = ST_IDLE;
          end else if (shift_val[RW_BIT]) begin
            state_d = ST_READ;
            head_d  = 1'b1;
            rd_d    = dly_q[shift_val[CH_MSB:CH_LSB]];
          end else begin
            state_d = ST_WRITE;
          end
        end else if (cs_rise) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_READ: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
          head_d  = 1'b0;
        end
      end
      ST_WRITE: begin
        if (sck_rise) begin
          shreg_d = shift_val[DW-2:0];
          cnt_d   = sat_inc(cnt_q);
        end
        // Final bit wins over a coincident cs_rise: commit, then leave.
        if (sck_rise && cnt_q == DATA_LAST) begin
          dly_d[ch_q] = shift_val;
          wr_d        = 1'b1;
          state_d     = cs_rise ? ST_IDLE : ST_DONE;
        end else if (cs_rise) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_DONE: begin
        if (cs_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      ch_q        <= '0;
      head_q      <= 1'b0;
      rd_q        <= '0;
      dly_q       <= {NCH{DLY_RST}};
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      mosi_sync_q <= '0;
      fill_q      <= '0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      ch_q        <= ch_d;
      head_q      <= head_d;
      rd_q        <= rd_d;
      dly_q       <= dly_d;
      wr_q        <= wr_d;
      err_q       <= err_d;
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      fill_q      <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      // Frames only start once cs has genuinely been seen high after reset.
      armed_q     <= armed_q | (fill_q[SYNC_STAGES] & cs_s);
    end
  end

  assign head_flag = head_q;
  assign rd_data   = rd_q;
  assign ch_dly    = dly_q;
  assign wr_pulse  = wr_q;
  assign frame_err = err_q;

endmodule
